ipmxb_hsst_rst_debounce_mc_v1_1: RTL and testbench

//   Multi-channel reset/status debouncer for the HSST reset sequencer. Each channel

---
 rtl/ipmxb_hsst_rst_debounce_mc_v1_1_if.sv | 36 +++
 rtl/ipmxb_hsst_rst_debounce_mc_v1_1.sv | 85 ++++++++
 tb/tb_ipmxb_hsst_rst_debounce_mc_v1_1.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ipmxb_hsst_rst_debounce_mc_v1_1_if.sv
// Channel bundle for the multi-channel HSST reset/status debouncer.
// Master drives raw levels and glitch clear; slave returns filtered status.
interface ipmxb_hsst_rst_debounce_mc_v1_1_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] signal_b;
  logic              glitch_clr;
  logic [CH_NUM-1:0] signal_deb;
  logic [CH_NUM-1:0] rise_pulse;
  logic [CH_NUM-1:0] fall_pulse;
  logic [CH_NUM-1:0] glitch_flag;
  logic              all_released;
  logic              any_asserted;

  modport master (
    output signal_b,
    output glitch_clr,
    input  signal_deb,
    input  rise_pulse,
    input  fall_pulse,
    input  glitch_flag,
    input  all_released,
    input  any_asserted
  );

  modport slave (
    input  signal_b,
    input  glitch_clr,
    output signal_deb,
    output rise_pulse,
    output fall_pulse,
    output glitch_flag,
    output all_released,
    output any_asserted
  );
endinterface

// File: rtl/ipmxb_hsst_rst_debounce_mc_v1_1.sv
// Vectorised reset/status debouncer: per-channel sync chain, asymmetric
// release/assert qualification, edge pulses and sticky glitch flags.
module ipmxb_hsst_rst_debounce_mc_v1_1 #(
  parameter int                   CH_NUM          = 4,
  parameter int                   CNTR_WIDTH      = 12,
  parameter logic [CNTR_WIDTH-1:0] RISE_CNTR_VALUE = 12'd2048,
  parameter logic [CNTR_WIDTH-1:0] FALL_CNTR_VALUE = 12'd0,
  parameter int                   SYNC_STAGES     = 2,
  parameter logic [CH_NUM-1:0]    ACTIVE_HIGH     = {CH_NUM{1'b0}}
) (
  input logic clk,
  input logic rst,
  ipmxb_hsst_rst_debounce_mc_v1_1_if.slave bus
);

  localparam logic [CNTR_WIDTH-1:0] ONE    = CNTR_WIDTH'(1);
  localparam logic [CNTR_WIDTH-1:0] RISE_T = RISE_CNTR_VALUE;
  // A zero assert count still needs one qualifying sample
  localparam logic [CNTR_WIDTH-1:0] FALL_T =
    (FALL_CNTR_VALUE == '0) ? ONE : FALL_CNTR_VALUE;

  logic [SYNC_STAGES-1:0][CH_NUM-1:0]     sync_q;
  logic [CH_NUM-1:0]                      lvl;
  logic [CH_NUM-1:0]                      sync_out;
  logic [CH_NUM-1:0]                      st_q, st_d;
  logic [CH_NUM-1:0][CNTR_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CH_NUM-1:0]                      rise_q, rise_d;
  logic [CH_NUM-1:0]                      fall_q, fall_d;
  logic [CH_NUM-1:0]                      glitch_q, glitch_d;
  logic [CH_NUM-1:0]                      glitch_set;

  assign lvl      = bus.signal_b ^ ACTIVE_HIGH;
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    rise_d     = '0;
    fall_d     = '0;
    glitch_set = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (sync_out[i] == st_q[i]) begin
        cnt_d[i]      = '0;
        glitch_set[i] = (cnt_q[i] != '0);
      end else if ((cnt_q[i] + ONE) ==
                   (st_q[i] ? FALL_T : RISE_T)) begin
        cnt_d[i]  = '0;
        st_d[i]   = ~st_q[i];
        rise_d[i] = ~st_q[i];
        fall_d[i] = st_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
    // A new glitch outranks a simultaneous clear
    glitch_d = (glitch_q & ~{CH_NUM{bus.glitch_clr}})
             | glitch_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      st_q     <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], lvl};
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign bus.signal_deb   = st_q ^ ACTIVE_HIGH;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.glitch_flag  = glitch_q;
  assign bus.all_released = &st_q;
  assign bus.any_asserted = |(~st_q);

endmodule

// File: tb/tb_ipmxb_hsst_rst_debounce_mc_v1_1.sv
// Directed bench for the multi-channel debouncer: three instances
// (defaults, 16-sample assert filter, mixed polarity) and a result queue.
module tb_ipmxb_hsst_rst_debounce_mc_v1_1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ipmxb_hsst_rst_debounce_mc_v1_1_if #(.CH_NUM(4)) if0 ();
  ipmxb_hsst_rst_debounce_mc_v1_1_if #(.CH_NUM(4)) if1 ();
  ipmxb_hsst_rst_debounce_mc_v1_1_if #(.CH_NUM(4)) if2 ();

  ipmxb_hsst_rst_debounce_mc_v1_1 u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  ipmxb_hsst_rst_debounce_mc_v1_1 #(
    .FALL_CNTR_VALUE (12'd16)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  ipmxb_hsst_rst_debounce_mc_v1_1 #(
    .ACTIVE_HIGH (4'b0101)
  ) u2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    nvec++;
    if (sbq.size() == 0) begin
      nerr++;
      $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        nerr++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if0.signal_b = 4'b0000; if0.glitch_clr = 1'b0;
    if1.signal_b = 4'b0000; if1.glitch_clr = 1'b0;
    if2.signal_b = 4'b0101; if2.glitch_clr = 1'b0;
    push("rst_deb_u0", 32'h0);
    push("rst_deb_u2", 32'h5);
    push("rst_allrel", 32'h0);
    push("rst_anyas", 32'h1);
    push("rst_flag", 32'h0);
    push("rst_rise", 32'h0);
    tick(3);
    chk(if0.signal_deb);
    chk(if2.signal_deb);
    chk(if0.all_released);
    chk(if0.any_asserted);
    chk(if0.glitch_flag);
    chk(if0.rise_pulse);

    // release out of reset: ch0 on u0, all on u1, ch0 (active-low->high) on u2
    rst = 1'b0;
    if0.signal_b = 4'b0001;
    if1.signal_b = 4'b1111;
    if2.signal_b = 4'b0100;
    push("rel_early_u0", 32'h0);
    push("rel_u0", 32'h1);
    push("rel_rise_u0", 32'h1);
    push("rel_allrel", 32'h0);
    push("rel_anyas", 32'h1);
    push("rel_u1", 32'hF);
    push("ah_u2", 32'h4);
    push("ah_rise_u2", 32'h1);
    push("rel_rise_end", 32'h0);
    tick(2049);
    chk(if0.signal_deb);
    tick(1);
    chk(if0.signal_deb);
    chk(if0.rise_pulse);
    chk(if0.all_released);
    chk(if0.any_asserted);
    chk(if1.signal_deb);
    chk(if2.signal_deb);
    chk(if2.rise_pulse);
    tick(1);
    chk(if0.rise_pulse);

    // ch1 partial release aborted by a one-cycle assert
    if0.signal_b = 4'b0011;
    tick(1000);
    if0.signal_b = 4'b0001;
    tick(1);
    if0.signal_b = 4'b0011;
    push("glitch_u0", 32'h2);
    push("reqr_early", 32'h1);
    push("reqr_deb", 32'h3);
    push("reqr_rise", 32'h2);
    tick(2);
    chk(if0.glitch_flag);
    tick(2047);
    chk(if0.signal_deb);
    tick(1);
    chk(if0.signal_deb);
    chk(if0.rise_pulse);

    if0.glitch_clr = 1'b1;
    push("gclr_u0", 32'h0);
    tick(1);
    if0.glitch_clr = 1'b0;
    chk(if0.glitch_flag);

    // all channels released
    if0.signal_b = 4'b1111;
    push("allrel_early", 32'h0);
    push("allrel", 32'h1);
    push("allrel_anyas", 32'h0);
    push("allrel_rise", 32'hC);
    tick(2049);
    chk(if0.all_released);
    tick(1);
    chk(if0.all_released);
    chk(if0.any_asserted);
    chk(if0.rise_pulse);

    // assert with FALL=0 qualifies after 3 cycles
    if0.signal_b = 4'b1011;
    push("f0_early", 32'hF);
    push("f0_deb", 32'hB);
    push("f0_fall", 32'h4);
    push("f0_rise", 32'h0);
    push("f0_anyas", 32'h1);
    push("f0_allrel", 32'h0);
    push("f0_fall_end", 32'h0);
    tick(2);
    chk(if0.signal_deb);
    tick(1);
    chk(if0.signal_deb);
    chk(if0.fall_pulse);
    chk(if0.rise_pulse);
    chk(if0.any_asserted);
    chk(if0.all_released);
    tick(1);
    chk(if0.fall_pulse);

    // assert with FALL=16 qualifies after 18 cycles
    if1.signal_b = 4'b1011;
    push("f16_early", 32'hF);
    push("f16_deb", 32'hB);
    push("f16_fall", 32'h4);
    tick(17);
    chk(if1.signal_deb);
    tick(1);
    chk(if1.signal_deb);
    chk(if1.fall_pulse);

    // 15-cycle low on ch3 falls short of 16
    if1.signal_b = 4'b0011;
    tick(15);
    if1.signal_b = 4'b1011;
    push("f16_glitch", 32'h8);
    push("f16_nofall", 32'hB);
    tick(3);
    chk(if1.glitch_flag);
    chk(if1.signal_deb);

    // clear lands on the same edge as a new ch0 glitch
    if1.signal_b = 4'b1010;
    tick(3);
    if1.signal_b = 4'b1011;
    tick(2);
    if1.glitch_clr = 1'b1;
    push("clr_vs_set", 32'h1);
    tick(1);
    if1.glitch_clr = 1'b0;
    chk(if1.glitch_flag);

    // reset just before the release edge
    rst = 1'b1;
    if0.signal_b = 4'b0000;
    if1.signal_b = 4'b0000;
    if2.signal_b = 4'b0101;
    tick(2);
    rst = 1'b0;
    if0.signal_b = 4'b0001;
    push("mid_early", 32'h0);
    push("mid_rst_deb", 32'h0);
    push("mid_rst_rise", 32'h0);
    push("mid_rst_allrel", 32'h0);
    push("mid_rst_anyas", 32'h1);
    push("mid_rst_flag_u1", 32'h0);
    push("mid_rst_deb_u2", 32'h5);
    push("restart_early", 32'h0);
    push("restart_deb", 32'h1);
    push("restart_rise", 32'h1);
    tick(2049);
    chk(if0.signal_deb);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk(if0.signal_deb);
    chk(if0.rise_pulse);
    chk(if0.all_released);
    chk(if0.any_asserted);
    chk(if1.glitch_flag);
    chk(if2.signal_deb);
    tick(2049);
    chk(if0.signal_deb);
    tick(1);
    chk(if0.signal_deb);
    chk(if0.rise_pulse);

    if (sbq.size() != 0) begin
      nerr++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
